// File: rtl/lut_key_finder_pkg.sv
// Shared definitions for the LUT key finder: FSM encoding, index width and
// the {key, data} pair layout used by the forward mux blocks as well.
package lut_key_finder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_t;

  // Index width never collapses to zero, even for a single-entry table.
  function automatic int idx_width(input int nr_key);
    return (nr_key > 1) ? $clog2(nr_key) : 1;
  endfunction

  // A pair is {key, data}: key in the upper bits, data in the lower bits.
  function automatic int pair_width(input int key_len, input int data_len);
    return key_len + data_len;
  endfunction

endpackage

// File: rtl/lut_key_finder_entry_slice.sv
// lut_entry_slice: combinational extraction of key/data of entry idx from a
// packed {key, data} LUT.
module lut_entry_slice
  import lut_key_finder_pkg::*;
#(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1,
  localparam int IDX_W   = idx_width(NR_KEY),
  localparam int P       = pair_width(KEY_LEN, DATA_LEN)
) (
  input  logic [NR_KEY*P-1:0] lut,
  input  logic [IDX_W-1:0]    idx,
  output logic [KEY_LEN-1:0]  key,
  output logic [DATA_LEN-1:0] data
);

  logic [P-1:0] pairs [NR_KEY];
  logic [P-1:0] entry;

  for (genvar g = 0; g < NR_KEY; g++) begin : g_pair
    assign pairs[g] = lut[g*P +: P];
  end

  assign entry = pairs[idx];
  assign key   = entry[P-1:DATA_LEN];
  assign data  = entry[DATA_LEN-1:0];

endmodule

// File: rtl/lut_key_finder.sv
// Reverse LUT search: returns the key of the lowest-index entry whose data
// equals the request. LUT_KEY_FINDER_PARALLEL_EN selects a one-cycle scan.
module lut_key_finder
  import lut_key_finder_pkg::*;
#(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1,
  localparam int IDX_W   = idx_width(NR_KEY),
  localparam int LUT_W   = NR_KEY * pair_width(KEY_LEN, DATA_LEN)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [DATA_LEN-1:0] req_data,
  input  logic [KEY_LEN-1:0]  default_key,
  input  logic [LUT_W-1:0]    lut,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [KEY_LEN-1:0]  rsp_key,
  output logic                rsp_hit,
  output logic [IDX_W-1:0]    rsp_idx
);

  state_t state_q, state_d;
  logic   cap_en, rsp_load, rsp_clr;

  logic [DATA_LEN-1:0] req_data_p0;
  logic [KEY_LEN-1:0]  def_key_p0;
  logic [LUT_W-1:0]    lut_p0;

  logic                match_any, last_entry;
  logic [KEY_LEN-1:0]  match_key;
  logic [IDX_W-1:0]    match_idx;

  logic                vld_p1, rsp_hit_p1;
  logic [KEY_LEN-1:0]  rsp_key_p1;
  logic [IDX_W-1:0]    rsp_idx_p1;

  // Stage p0: request, default key and table captured at acceptance
  always_ff @(posedge clk) begin
    if (cap_en) begin
      req_data_p0 <= req_data;
      def_key_p0  <= default_key;
      lut_p0      <= lut;
    end
  end

`ifndef LUT_KEY_FINDER_PARALLEL_EN
  logic [IDX_W-1:0]    idx_p0;
  logic [KEY_LEN-1:0]  cur_key;
  logic [DATA_LEN-1:0] cur_data;

  lut_entry_slice #(
    .NR_KEY  (NR_KEY),
    .KEY_LEN (KEY_LEN),
    .DATA_LEN(DATA_LEN)
  ) u_slice (
    .lut (lut_p0),
    .idx (idx_p0),
    .key (cur_key),
    .data(cur_data)
  );

  // Counter stops at the last entry; the FSM leaves SCAN there.
  always_ff @(posedge clk) begin
    if (!rst_n)                                 idx_p0 <= '0;
    else if (cap_en)                            idx_p0 <= '0;
    else if (state_q == SCAN && !last_entry)    idx_p0 <= idx_p0 + 1'b1;
  end

  always_comb begin
    match_any  = (cur_data == req_data_p0);
    match_key  = cur_key;
    match_idx  = idx_p0;
    last_entry = (idx_p0 == IDX_W'(NR_KEY - 1));
  end
`else
  logic [KEY_LEN-1:0]  all_key  [NR_KEY];
  logic [DATA_LEN-1:0] all_data [NR_KEY];

  for (genvar g = 0; g < NR_KEY; g++) begin : g_slice
    lut_entry_slice #(
      .NR_KEY  (NR_KEY),
      .KEY_LEN (KEY_LEN),
      .DATA_LEN(DATA_LEN)
    ) u_slice (
      .lut (lut_p0),
      .idx (IDX_W'(g)),
      .key (all_key[g]),
      .data(all_data[g])
    );
  end

  // Walk from the top down so the lowest matching index is the last to win.
  always_comb begin
    match_any  = 1'b0;
    match_key  = '0;
    match_idx  = '0;
    last_entry = 1'b1;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (all_data[i] == req_data_p0) begin
        match_any = 1'b1;
        match_key = all_key[i];
        match_idx = IDX_W'(i);
      end
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    cap_en   = 1'b0;
    rsp_load = 1'b0;
    rsp_clr  = 1'b0;
    unique case (state_q)
      IDLE: if (req_valid) begin
        cap_en  = 1'b1;
        state_d = SCAN;
      end
      SCAN: if (match_any || last_entry) begin
        rsp_load = 1'b1;
        state_d  = RESP;
      end
      RESP: if (rsp_ready) begin
        rsp_clr = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: response registers, held until the consumer accepts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vld_p1     <= 1'b0;
      rsp_key_p1 <= '0;
      rsp_hit_p1 <= 1'b0;
      rsp_idx_p1 <= '0;
    end else begin
      state_q <= state_d;
      if (rsp_load) begin
        vld_p1     <= 1'b1;
        rsp_hit_p1 <= match_any;
        rsp_key_p1 <= match_any ? match_key : def_key_p0;
        rsp_idx_p1 <= match_any ? match_idx : '0;
      end else if (rsp_clr) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = vld_p1;
  assign rsp_key   = rsp_key_p1;
  assign rsp_hit   = rsp_hit_p1;
  assign rsp_idx   = rsp_idx_p1;

endmodule

// File: tb/tb_lut_key_finder.sv
// Directed bench for lut_key_finder (NR_KEY=4, KEY_LEN=2, DATA_LEN=4) with a
// per-cycle reference model; honours LUT_KEY_FINDER_PARALLEL_EN.
module tb_lut_key_finder;

`ifdef LUT_KEY_FINDER_PARALLEL_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  localparam logic [23:0] LUT0 = {6'b11_1010, 6'b10_0101, 6'b01_0101, 6'b00_0011};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_data = 4'h0;
  logic [1:0]  default_key = 2'b00;
  logic [23:0] lut = LUT0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_key;
  logic        rsp_hit;
  logic [1:0]  rsp_idx;

  int tests = 0;
  int fails = 0;

  lut_key_finder #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .default_key(default_key), .lut(lut),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_key(rsp_key),
    .rsp_hit(rsp_hit), .rsp_idx(rsp_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         hit;
    logic [1:0] key;
    logic [1:0] idx;
    int         lat;
  } res_t;

  // Reference: first entry (lowest index) whose data equals d.
  function automatic res_t search(input logic [23:0] l, input logic [3:0] d,
                                  input logic [1:0] dk);
    res_t r;
    r.hit = 1'b0; r.key = dk; r.idx = 2'd0; r.lat = 4;
    for (int i = 0; i < 4; i++) begin
      if (!r.hit && l[i*6 +: 4] == d) begin
        r.hit = 1'b1; r.key = l[i*6+4 +: 2]; r.idx = 2'(i); r.lat = i + 1;
      end
    end
    if (PAR) r.lat = 1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle model: checked and advanced on every falling edge.
  bit         m_busy = 1'b0, m_valid = 1'b0, m_fresh = 1'b1;
  logic [1:0] m_key = 2'b00, m_idx = 2'b00;
  bit         m_hit = 1'b0;
  int         m_wait = 0;
  res_t       m_pend;

  always @(negedge clk) begin
    chk("req_ready", 32'(req_ready), 32'(!m_busy));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    if (m_valid || m_fresh) begin
      chk("rsp_key", 32'(rsp_key), 32'(m_key));
      chk("rsp_hit", 32'(rsp_hit), 32'(m_hit));
      chk("rsp_idx", 32'(rsp_idx), 32'(m_idx));
    end
    if (!rst_n) begin
      m_busy = 1'b0; m_valid = 1'b0; m_fresh = 1'b1;
      m_key = 2'b00; m_hit = 1'b0; m_idx = 2'b00;
    end else if (m_valid) begin
      if (rsp_ready) begin m_valid = 1'b0; m_busy = 1'b0; end
    end else if (m_busy) begin
      m_wait--;
      if (m_wait == 0) begin
        m_valid = 1'b1; m_key = m_pend.key; m_hit = m_pend.hit; m_idx = m_pend.idx;
      end
    end else if (req_valid) begin
      m_pend  = search(lut, req_data, default_key);
      m_wait  = m_pend.lat;
      m_busy  = 1'b1;
      m_fresh = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [3:0] d, input logic [1:0] dk);
    int n = 0;
    while (!req_ready && n < 50) begin cyc(); n++; end
    chk("idle_before_issue", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_data = d; default_key = dk;
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input logic [1:0] key, input bit hit,
                          input logic [1:0] idx, input int lat);
    int n = 0;
    while (!rsp_valid && n < 20) begin cyc(); n++; end
    chk({name, "_latency"}, 32'(n), 32'(lat));
    chk({name, "_key"}, 32'(rsp_key), 32'(key));
    chk({name, "_hit"}, 32'(rsp_hit), 32'(hit));
    chk({name, "_idx"}, 32'(rsp_idx), 32'(idx));
  endtask

  task automatic ack();
    rsp_ready = 1'b1; cyc(); rsp_ready = 1'b0;
  endtask

  initial begin
    res_t r;
    // Pin the model against hand-computed results.
    r = search(LUT0, 4'h5, 2'b00);
    chk("pin_h5_key", 32'(r.key), 32'd1);
    chk("pin_h5_idx", 32'(r.idx), 32'd1);
    chk("pin_h5_lat", 32'(r.lat), PAR ? 32'd1 : 32'd2);
    r = search(LUT0, 4'hF, 2'b10);
    chk("pin_hF_hit", 32'(r.hit), 32'd0);
    chk("pin_hF_key", 32'(r.key), 32'd2);

    cyc(); cyc();
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("post_reset_ready", 32'(req_ready), 32'd1);

    // Test 1: hit at idx0
    issue(4'h3, 2'b11);
    wait_rsp("t1", 2'b00, 1'b1, 2'd0, 1);
    ack();
    chk("t1_valid_drops", 32'(rsp_valid), 32'd0);

    // Test 2: duplicate data, lowest index wins
    issue(4'h5, 2'b11);
    wait_rsp("t2", 2'b01, 1'b1, 2'd1, PAR ? 1 : 2);
    ack();

    // Test 3: miss, rsp_ready held high beforehand (ignored while idle/scanning)
    rsp_ready = 1'b1;
    issue(4'hF, 2'b10);
    wait_rsp("t3", 2'b10, 1'b0, 2'd0, PAR ? 1 : 4);
    cyc();
    rsp_ready = 1'b0;
    chk("t3_valid_drops", 32'(rsp_valid), 32'd0);

    // Extra: hit at last entry, and a second miss with another default key
    issue(4'hA, 2'b00);
    wait_rsp("last", 2'b11, 1'b1, 2'd3, PAR ? 1 : 4);
    ack();
    issue(4'h7, 2'b01);
    wait_rsp("miss2", 2'b01, 1'b0, 2'd0, PAR ? 1 : 4);
    ack();

    // Test 4: back-pressure with a pending new request
    issue(4'h3, 2'b00);
    wait_rsp("t4", 2'b00, 1'b1, 2'd0, 1);
    req_valid = 1'b1; req_data = 4'hA;
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t4_hold_key", 32'(rsp_key), 32'd0);
      chk("t4_hold_ready", 32'(req_ready), 32'd0);
      cyc();
    end
    rsp_ready = 1'b1; cyc(); rsp_ready = 1'b0;
    chk("t4_ready_back", 32'(req_ready), 32'd1);
    cyc();
    req_valid = 1'b0;
    wait_rsp("t4_next", 2'b11, 1'b1, 2'd3, PAR ? 1 : 4);
    ack();

    // Test 5: inputs changed after acceptance have no effect
    issue(4'hA, 2'b01);
    lut[21:18] = 4'h0; req_data = 4'h3; default_key = 2'b10;
    wait_rsp("t5", 2'b11, 1'b1, 2'd3, PAR ? 1 : 4);
    ack();
    lut = LUT0;

    // Test 6: reset during the second SCAN cycle of a miss search
    issue(4'hF, 2'b01);
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("t6_ready", 32'(req_ready), 32'd1);
    chk("t6_valid", 32'(rsp_valid), 32'd0);
    chk("t6_key", 32'(rsp_key), 32'd0);
    chk("t6_hit", 32'(rsp_hit), 32'd0);
    chk("t6_idx", 32'(rsp_idx), 32'd0);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // Recovery after reset
    issue(4'h5, 2'b00);
    wait_rsp("t6_recover", 2'b01, 1'b1, 2'd1, PAR ? 1 : 2);
    ack();
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lut_key_finder.md
Name: lut_key_finder

Overview:
- Reverse lookup companion to the key-indexed multiplexers: given a data value, returns the key of the first LUT pair whose data field matches.
- Uses the same packed LUT format, so one table serves both the forward mux and this reverse search.
- Sequential: scans one entry per cycle under a valid/ready request/response handshake, and returns a default key on a miss.

Parameters:
- NR_KEY, 2, number of {key,data} pairs in the LUT.
- KEY_LEN, 1, key width in bits.
- DATA_LEN, 1, data width in bits.
- Derived localparam IDX_W = max(1, clog2(NR_KEY)).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_data  in  DATA_LEN  value to search for.
- default_key  in  KEY_LEN  key returned on miss; sampled at acceptance.
- lut  in  NR_KEY*(KEY_LEN+DATA_LEN)  packed pairs.
  - Entry i occupies bits [(i+1)*P-1 : i*P], where P = KEY_LEN+DATA_LEN.
  - Key is in the upper KEY_LEN bits of the entry; data is in the lower DATA_LEN bits.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer accepts the result.
- rsp_key  out  KEY_LEN  matched key, or default_key on miss.
- rsp_hit  out  1  1 = match found.
- rsp_idx  out  IDX_W  index of the matching entry; 0 on miss.

Behaviour:
- Reset (rst_n low at a rising edge):
  - State goes to IDLE; rsp_valid=0, rsp_key=0, rsp_hit=0, rsp_idx=0.
  - req_ready=1 in the first cycle after reset release.
- Reset mid-scan or mid-response discards the operation; no partial response is ever emitted.
- FSM states:
  - IDLE: req_ready=1. On req_valid&req_ready (edge T0), capture req_data, default_key and the full lut into registers, clear idx to 0, go to SCAN.
  - SCAN: req_ready=0. Each cycle, compare the captured entry[idx].data with the captured req_data.
    - On match: load rsp_key=entry[idx].key, rsp_hit=1, rsp_idx=idx; go to RESP.
    - On no match at idx=NR_KEY-1: load rsp_key=default_key, rsp_hit=0, rsp_idx=0; go to RESP.
    - Otherwise: idx increments.
  - RESP: rsp_valid=1; outputs are held stable until rsp_valid&rsp_ready, then go to IDLE with rsp_valid=0 on the following cycle.
- Latency:
  - Hit at entry i: rsp_valid rises at edge T0+i+1.
  - Miss: rsp_valid rises at edge T0+NR_KEY.
  - Throughput: one request per (scan cycles + 1 response-accept cycle + 1 IDLE cycle).
- Priority: the lowest index wins when several entries share the same data value.
- Inputs after acceptance:
  - lut, req_data and default_key changes have no effect on the result (captured copy).
  - req_valid is ignored while not IDLE.
- rsp_ready while rsp_valid=0 is ignored.
- Comparison is exact equality over all DATA_LEN bits.
- idx counter width is IDX_W. It never exceeds NR_KEY-1; there is no wrap because the FSM leaves SCAN at NR_KEY-1.
- NR_KEY=1: the scan takes exactly one cycle.

Optional Feature:
- Macro LUT_KEY_FINDER_PARALLEL_EN.
- Defined:
  - All NR_KEY entries are compared in one cycle through a lowest-index-first priority encoder.
  - SCAN lasts exactly one cycle, so rsp_valid rises at T0+1 for both hit and miss.
  - rsp_key, rsp_hit and rsp_idx values are identical to serial mode.
- Undefined: serial one-entry-per-cycle scan as above.
- Handshake, reset and RESP behaviour are identical in both modes.

Decomposition:
- Shared package/header holds:
  - FSM state encoding (IDLE=2'd0, SCAN=2'd1, RESP=2'd2);
  - the IDX_W computation;
  - the pair-slicing convention (key upper, data lower), common with the forward mux blocks.
- One natural sub-module, lut_entry_slice: parameters NR_KEY, KEY_LEN, DATA_LEN; combinationally extracts key/data of entry idx from the packed lut.
  - Serial mode: one instance.
  - Parallel mode: one instance per entry, generate loop.

Test Plan:
- Common config: NR_KEY=4, KEY_LEN=2, DATA_LEN=4.
- Common LUT: idx0 {00,3}, idx1 {01,5}, idx2 {10,5}, idx3 {11,A}.
- Test 1: req_data=4'h3 accepted at T0 -> rsp_valid at T0+1, rsp_key=2'b00, rsp_hit=1, rsp_idx=0.
- Test 2: req_data=4'h5 -> rsp_key=2'b01, rsp_idx=1 (first match beats idx2), rsp_valid at T0+2; parallel build: at T0+1.
- Test 3: req_data=4'hF, default_key=2'b10 -> rsp_hit=0, rsp_key=2'b10, rsp_idx=0, rsp_valid at T0+4.
- Test 4: rsp_ready held 0 for 5 cycles after rsp_valid; req_valid=1 with new data -> outputs stable, req_ready=0, new request not taken until the response handshake completes and req_ready returns to 1.
- Test 5: after acceptance of req_data=4'hA, overwrite lut entry3 data to 4'h0 -> response still rsp_key=2'b11, rsp_hit=1, rsp_idx=3.
- Test 6: rst_n=0 at the 2nd SCAN cycle of a miss search -> next cycle state IDLE, rsp_valid=0, all rsp outputs 0, req_ready=1; no response for the aborted request ever appears.
